// File: rtl/cache_nway_wb_pkg.sv
// Shared types and helpers for the N-way set-associative write-back cache.
package cache_nway_wb_pkg;

    localparam int LC3B_OFFSET_W = 4;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;
    typedef logic [1:0]   lc3b_mem_wmask;

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} cache_state_t;

    // Byte-masked store of one 16-bit word into a 128-bit line.
    function automatic lc3b_line merge_word(input lc3b_line      line,
                                            input logic [2:0]    word,
                                            input lc3b_word      wdata,
                                            input lc3b_mem_wmask be);
        lc3b_line res;
        res = line;
        if (be[0]) res[{word, 4'h0} +: 8] = wdata[7:0];
        if (be[1]) res[{word, 4'h8} +: 8] = wdata[15:8];
        return res;
    endfunction

endpackage

// File: rtl/cache_nway_wb_if.sv
// CPU-side and physical-memory-side buses of the cache.
interface cache_nway_wb_if;
    import cache_nway_wb_pkg::*;

    logic [15:0]   mem_address;
    logic          mem_read;
    logic          mem_write;
    lc3b_word      mem_wdata;
    lc3b_mem_wmask mem_byte_enable;
    lc3b_word      mem_rdata;
    logic          mem_resp;

    logic [15:0]   pmem_address;
    logic          pmem_read;
    logic          pmem_write;
    lc3b_line      pmem_wdata;
    lc3b_line      pmem_rdata;
    logic          pmem_resp;

    modport slave (
        input  mem_address, mem_read, mem_write, mem_wdata, mem_byte_enable,
        output mem_rdata, mem_resp,
        output pmem_address, pmem_read, pmem_write, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output mem_address, mem_read, mem_write, mem_wdata, mem_byte_enable,
        input  mem_rdata, mem_resp,
        input  pmem_address, pmem_read, pmem_write, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

endinterface

// File: rtl/cache_nway_wb_plru.sv
// Per-set tree pseudo-LRU: heap-ordered node bits, 0 steers the victim to the lower half.
module cache_nway_wb_plru #(
    parameter int WAYS = 4,
    parameter int SETS = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [$clog2(SETS)-1:0]  idx,
    input  logic                     touch,
    input  logic [$clog2(WAYS)-1:0]  touch_way,
    output logic [$clog2(WAYS)-1:0]  victim
);
    localparam int WAY_W = $clog2(WAYS);

    // Top bit is padding so a node index of WAY_W bits addresses the tree directly.
    typedef logic [WAYS-1:0]  tree_t;
    typedef logic [WAY_W-1:0] node_t;

    tree_t plru_q [SETS];
    tree_t plru_d [SETS];
    tree_t cur;
    tree_t nxt;

    always_comb begin
        node_t vnode;
        cur    = plru_q[idx];
        vnode  = '0;
        victim = '0;
        for (int l = 0; l < WAY_W; l++) begin
            victim = (victim << 1) | node_t'(cur[vnode]);
            vnode  = node_t'(2 * int'(vnode) + 1 + int'(cur[vnode]));
        end
    end

    always_comb begin
        node_t unode;
        node_t path;
        plru_d = plru_q;
        nxt    = plru_q[idx];
        unode  = '0;
        path   = touch_way;
        for (int l = 0; l < WAY_W; l++) begin
            nxt[unode] = ~path[WAY_W-1];
            unode      = node_t'(2 * int'(unode) + 1 + int'(path[WAY_W-1]));
            path       = path << 1;
        end
        if (touch) plru_d[idx] = nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
        end else begin
            plru_q <= plru_d;
        end
    end

endmodule

// File: rtl/cache_nway_wb.sv
// N-way set-associative write-back/write-allocate cache with integrated control FSM.
//   state     | meaning
//   IDLE      | waiting for a CPU read or write
//   COMPARE   | tag lookup; hit completes the request, miss picks a victim
//   WRITEBACK | dirty victim line being written to physical memory
//   ALLOCATE  | requested line being fetched into the victim way
module cache_nway_wb
    import cache_nway_wb_pkg::*;
#(
    parameter int WAYS  = 4,
    parameter int SETS  = 8,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    cache_nway_wb_if.slave    bus,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count,
    output logic [CNT_W-1:0]  wb_count
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 16 - LC3B_OFFSET_W - IDX_W;
    localparam int WAY_W = $clog2(WAYS);

    typedef logic [WAY_W-1:0] way_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [TAG_W-1:0] addr_tag;
    logic [IDX_W-1:0] addr_idx;
    logic [2:0]       addr_word;
    logic             unused_addr_bit;

    assign addr_tag        = bus.mem_address[15 -: TAG_W];
    assign addr_idx        = bus.mem_address[LC3B_OFFSET_W +: IDX_W];
    assign addr_word       = bus.mem_address[3:1];
    assign unused_addr_bit = bus.mem_address[0];

    lc3b_line         data_q [WAYS][SETS];
    logic [TAG_W-1:0] tag_q  [WAYS][SETS];
    logic [SETS-1:0]  valid_q [WAYS];
    logic [SETS-1:0]  valid_d [WAYS];
    logic [SETS-1:0]  dirty_q [WAYS];
    logic [SETS-1:0]  dirty_d [WAYS];

    cache_state_t     state_q, state_d;
    way_t             victim_q, victim_d;
    logic             pmem_read_q, pmem_read_d;
    logic             pmem_write_q, pmem_write_d;
    logic [15:0]      pmem_addr_q, pmem_addr_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0] wb_cnt_q, wb_cnt_d;

    logic     hit;
    way_t     hit_way;
    logic     has_free;
    way_t     free_way;
    way_t     plru_victim;
    way_t     miss_way;
    lc3b_line hit_line;
    logic     arr_we;
    way_t     arr_way;
    lc3b_line arr_line;

    // Downward scan leaves the lowest-numbered invalid way in free_way.
    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        has_free = 1'b0;
        free_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[w][addr_idx] && (tag_q[w][addr_idx] == addr_tag)) begin
                hit     = 1'b1;
                hit_way = way_t'(w);
            end
            if (!valid_q[w][addr_idx]) begin
                has_free = 1'b1;
                free_way = way_t'(w);
            end
        end
    end

    assign miss_way = has_free ? free_way : plru_victim;
    assign hit_line = data_q[hit_way][addr_idx];

    cache_nway_wb_plru #(.WAYS(WAYS), .SETS(SETS)) u_plru (
        .clk       (clk),
        .rst_n     (rst_n),
        .idx       (addr_idx),
        .touch     ((state_q == COMPARE) && hit),
        .touch_way (hit_way),
        .victim    (plru_victim)
    );

    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        pmem_read_d  = pmem_read_q;
        pmem_write_d = pmem_write_q;
        pmem_addr_d  = pmem_addr_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        wb_cnt_d     = wb_cnt_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        arr_we       = 1'b0;
        arr_way      = victim_q;
        arr_line     = bus.pmem_rdata;
        unique case (state_q)
            IDLE: begin
                if (bus.mem_read || bus.mem_write) state_d = COMPARE;
            end
            COMPARE: begin
                if (hit) begin
                    hit_cnt_d = sat_inc(hit_cnt_q);
                    if (bus.mem_write) begin
                        arr_we   = 1'b1;
                        arr_way  = hit_way;
                        arr_line = merge_word(hit_line, addr_word, bus.mem_wdata, bus.mem_byte_enable);
                        dirty_d[hit_way][addr_idx] = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    miss_cnt_d = sat_inc(miss_cnt_q);
                    victim_d   = miss_way;
                    if (dirty_q[miss_way][addr_idx]) begin
                        pmem_write_d = 1'b1;
                        pmem_addr_d  = {tag_q[miss_way][addr_idx], addr_idx, 4'h0};
                        state_d      = WRITEBACK;
                    end else begin
                        pmem_read_d = 1'b1;
                        pmem_addr_d = {bus.mem_address[15:4], 4'h0};
                        state_d     = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                if (bus.pmem_resp) begin
                    wb_cnt_d                    = sat_inc(wb_cnt_q);
                    dirty_d[victim_q][addr_idx] = 1'b0;
                    pmem_write_d                = 1'b0;
                    pmem_read_d                 = 1'b1;
                    pmem_addr_d                 = {bus.mem_address[15:4], 4'h0};
                    state_d                     = ALLOCATE;
                end
            end
            ALLOCATE: begin
                if (bus.pmem_resp) begin
                    arr_we                      = 1'b1;
                    valid_d[victim_q][addr_idx] = 1'b1;
                    dirty_d[victim_q][addr_idx] = 1'b0;
                    pmem_read_d                 = 1'b0;
                    state_d                     = COMPARE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            victim_q     <= '0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            pmem_addr_q  <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            wb_cnt_q     <= '0;
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
            end
        end else begin
            state_q      <= state_d;
            victim_q     <= victim_d;
            pmem_read_q  <= pmem_read_d;
            pmem_write_q <= pmem_write_d;
            pmem_addr_q  <= pmem_addr_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            wb_cnt_q     <= wb_cnt_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
        end
    end

    // Line storage carries no reset; the valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (arr_we) begin
            data_q[arr_way][addr_idx] <= arr_line;
            tag_q[arr_way][addr_idx]  <= addr_tag;
        end
    end

    assign bus.mem_resp     = (state_q == COMPARE) && hit;
    assign bus.mem_rdata    = hit_line[{addr_word, 4'h0} +: 16];
    assign bus.pmem_address = pmem_addr_q;
    assign bus.pmem_read    = pmem_read_q;
    assign bus.pmem_write   = pmem_write_q;
    assign bus.pmem_wdata   = data_q[victim_q][addr_idx];

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
    assign wb_count   = wb_cnt_q;

endmodule

// File: tb/tb_cache_nway_wb.sv
// Directed and random checks of cache_nway_wb against a transaction-level cache model.
module tb_cache_nway_wb;
    import cache_nway_wb_pkg::*;

    localparam int WAYS  = 4;
    localparam int SETS  = 8;
    localparam int CNT_W = 4;
    localparam int IDX_W = $clog2(SETS);
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [CNT_W-1:0] hit_count, miss_count, wb_count;

    cache_nway_wb_if bus();

    cache_nway_wb #(.WAYS(WAYS), .SETS(SETS), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .wb_count   (wb_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic lc3b_line init_line(input int a);
        lc3b_line l;
        for (int i = 0; i < 8; i++) l[i*16 +: 16] = lc3b_word'(a + i * 16'h0101) ^ 16'h5A5A;
        return l;
    endfunction

    // Physical memory as seen by the responder.
    lc3b_line pmem_arr [int];
    int       fill_log [$];
    int       wb_addr_log [$];
    lc3b_line wb_data_log [$];
    int       pmem_cyc = 0;

    initial begin
        int cnt;
        cnt = 0;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.pmem_resp) begin
                bus.pmem_resp = 1'b0;
                cnt = 0;
            end else if (!rst_n) begin
                cnt = 0;
            end else if (bus.pmem_read || bus.pmem_write) begin
                pmem_cyc++;
                cnt++;
                if (cnt >= 3) begin
                    if (bus.pmem_write) begin
                        pmem_arr[int'(bus.pmem_address)] = bus.pmem_wdata;
                        wb_addr_log.push_back(int'(bus.pmem_address));
                        wb_data_log.push_back(bus.pmem_wdata);
                    end else begin
                        bus.pmem_rdata = pmem_arr.exists(int'(bus.pmem_address)) ?
                                         pmem_arr[int'(bus.pmem_address)] : init_line(int'(bus.pmem_address));
                        fill_log.push_back(int'(bus.pmem_address));
                    end
                    bus.pmem_resp = 1'b1;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Transaction-level reference model.
    int       m_tag   [SETS][WAYS];
    bit       m_valid [SETS][WAYS];
    bit       m_dirty [SETS][WAYS];
    lc3b_line m_data  [SETS][WAYS];
    bit       m_tree  [SETS][WAYS-1];
    lc3b_line model_mem [int];
    int       m_hits, m_miss, m_wbs;
    bit       e_miss, e_wb;
    int       e_wb_addr, e_fill_addr;
    lc3b_line e_wb_data;
    lc3b_word e_rdata;
    lc3b_word last_rdata;

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
            for (int n = 0; n < WAYS - 1; n++) m_tree[s][n] = 1'b0;
        end
        m_hits = 0;
        m_miss = 0;
        m_wbs  = 0;
    endtask

    task automatic model_op(input bit wr, input int a, input lc3b_word wd, input lc3b_mem_wmask be);
        int set, tag, word, way, node, n, p;
        set  = (a >> 4) % SETS;
        tag  = a >> (4 + IDX_W);
        word = (a >> 1) & 7;
        way  = -1;
        e_miss = 1'b0;
        e_wb   = 1'b0;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[set][w] && m_tag[set][w] == tag) way = w;
        if (way < 0) begin
            e_miss = 1'b1;
            if (m_miss < MAXC) m_miss++;
            for (int w = 0; w < WAYS; w++)
                if (!m_valid[set][w] && way < 0) way = w;
            if (way < 0) begin
                node = 0;
                while (node < WAYS - 1) node = 2 * node + 1 + int'(m_tree[set][node]);
                way = node - (WAYS - 1);
            end
            if (m_dirty[set][way]) begin
                e_wb      = 1'b1;
                e_wb_addr = (m_tag[set][way] * SETS + set) * 16;
                e_wb_data = m_data[set][way];
                model_mem[e_wb_addr] = e_wb_data;
                if (m_wbs < MAXC) m_wbs++;
            end
            e_fill_addr = a & 16'hFFF0;
            m_data[set][way]  = model_mem.exists(e_fill_addr) ? model_mem[e_fill_addr] : init_line(e_fill_addr);
            m_tag[set][way]   = tag;
            m_valid[set][way] = 1'b1;
            m_dirty[set][way] = 1'b0;
        end
        if (m_hits < MAXC) m_hits++;
        e_rdata = m_data[set][way][word*16 +: 16];
        if (wr) begin
            if (be[0]) m_data[set][way][word*16 +: 8]     = wd[7:0];
            if (be[1]) m_data[set][way][word*16 + 8 +: 8] = wd[15:8];
            m_dirty[set][way] = 1'b1;
        end
        n = way + WAYS - 1;
        while (n > 0) begin
            p = (n - 1) / 2;
            m_tree[set][p] = (n == 2 * p + 1);
            n = p;
        end
    endtask

    task automatic do_op(input bit wr, input int a, input lc3b_word wd, input lc3b_mem_wmask be,
                         input string tag);
        int n;
        lc3b_word got;
        fill_log.delete();
        wb_addr_log.delete();
        wb_data_log.delete();
        pmem_cyc = 0;
        model_op(wr, a, wd, be);
        @(negedge clk);
        bus.mem_address     = a[15:0];
        bus.mem_wdata       = wd;
        bus.mem_byte_enable = be;
        bus.mem_read        = !wr;
        bus.mem_write       = wr;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.mem_resp && n < 200);
        chk({tag, " resp"}, bus.mem_resp, 1'b1);
        got = bus.mem_rdata;
        last_rdata = got;
        @(posedge clk);
        #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        if (!wr) chk({tag, " rdata"}, got, e_rdata);
        if (!e_miss) begin
            chk({tag, " hit latency"}, n, 1);
            chk({tag, " pmem idle on hit"}, pmem_cyc, 0);
        end
        chk({tag, " fills"}, fill_log.size(), int'(e_miss));
        if (e_miss && fill_log.size() == 1) chk({tag, " fill addr"}, fill_log[0], e_fill_addr);
        chk({tag, " writebacks"}, wb_addr_log.size(), int'(e_wb));
        if (e_wb && wb_addr_log.size() == 1) begin
            chk({tag, " wb addr"}, wb_addr_log[0], e_wb_addr);
            chk({tag, " wb data"}, wb_data_log[0], e_wb_data);
        end
        chk({tag, " hit_count"}, hit_count, m_hits);
        chk({tag, " miss_count"}, miss_count, m_miss);
        chk({tag, " wb_count"}, wb_count, m_wbs);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk({tag, " mem_resp"}, bus.mem_resp, 1'b0);
        chk({tag, " pmem_read"}, bus.pmem_read, 1'b0);
        chk({tag, " pmem_write"}, bus.pmem_write, 1'b0);
        chk({tag, " counters"}, {hit_count, miss_count, wb_count}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        lc3b_line l;
        int n;
        bus.mem_address     = '0;
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_wdata       = '0;
        bus.mem_byte_enable = '0;

        l = init_line(16'h1230);
        l[47:32] = 16'hBEEF;
        pmem_arr[16'h1230]  = l;
        model_mem[16'h1230] = l;

        repeat (3) @(negedge clk);
        do_reset("reset");

        do_op(1'b0, 16'h1234, 16'h0, 2'b00, "t1 read miss");
        chk("t1 rdata", last_rdata, 16'hBEEF);
        chk("t1 miss_count", miss_count, 1);
        chk("t1 hit_count", hit_count, 1);

        do_op(1'b0, 16'h1234, 16'h0, 2'b00, "t2 read hit");
        chk("t2 hit_count", hit_count, 2);

        do_op(1'b1, 16'h1234, 16'hAA55, 2'b01, "t3 write");
        do_op(1'b0, 16'h1234, 16'h0, 2'b00, "t3 readback");
        chk("t3 merged", last_rdata, 16'hBE55);

        do_op(1'b0, 16'h12B4, 16'h0, 2'b00, "t4 fill way1");
        do_op(1'b0, 16'h1334, 16'h0, 2'b00, "t4 fill way2");
        do_op(1'b0, 16'h13B4, 16'h0, 2'b00, "t4 fill way3");
        do_op(1'b0, 16'h1434, 16'h0, 2'b00, "t4 evict");
        chk("t4 wb_count", wb_count, 1);
        chk("t4 wb addr", (wb_addr_log.size() == 1) ? wb_addr_log[0] : -1, 16'h1230);
        chk("t4 wb word2", (wb_data_log.size() == 1) ? wb_data_log[0][47:32] : 16'h0, 16'hBE55);
        chk("t4 fill addr", (fill_log.size() == 1) ? fill_log[0] : -1, 16'h1430);

        @(negedge clk);
        bus.mem_address = 16'h1234;
        bus.mem_read    = 1'b1;
        n = 0;
        while (!bus.pmem_read && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t5 in allocate", bus.pmem_read, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5 pmem_read drop", bus.pmem_read, 1'b0);
        chk("t5 mem_resp", bus.mem_resp, 1'b0);
        chk("t5 counters", {hit_count, miss_count, wb_count}, 0);
        bus.mem_read = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        do_op(1'b0, 16'h1234, 16'h0, 2'b00, "t5 post-reset");
        chk("t5 miss after reset", miss_count, 1);
        chk("t5 rdata from memory", last_rdata, 16'hBE55);

        for (int i = 0; i < 20; i++) do_op(1'b0, 16'h1234, 16'h0, 2'b00, "t6 hit");
        chk("t6 saturated", hit_count, 4'hF);

        for (int r = 0; r < 4; r++) begin
            do_reset("rand reset");
            for (int i = 0; i < 80; i++) begin
                int a;
                a = ((16'h40 + $urandom_range(0, 5)) << (4 + IDX_W)) | ($urandom_range(0, 1) << 4)
                    | ($urandom_range(0, 7) << 1) | $urandom_range(0, 1);
                do_op(1'($urandom_range(0, 1)), a, lc3b_word'($urandom), lc3b_mem_wmask'($urandom_range(0, 3)),
                      "rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
